// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg: shared types and sizes for the serial bus arbiter
package serial_bus_pkg;
  localparam int NUM_INIT = 2;
  localparam int INIT_ID_W = 1;
  typedef enum logic [1:0] {IDLE, GRANTED, RELEASE} arb_state_t;
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: saturating idle counter that flags when a granted owner has gone quiet too long
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] cnt;
  assign expire = inc && cnt == LAST;
  // count idle granted cycles, holding at the last value instead of wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != LAST) cnt <= cnt + 1'b1;
endmodule

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: two-initiator round-robin arbiter with split parking and idle watchdog
import serial_bus_pkg::*;
module serial_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_INIT-1:0]  req,
  input  logic                 bus_active,
  input  logic                 txn_done,
  input  logic                 target_split,
  input  logic                 split_resume,
  output logic [NUM_INIT-1:0]  grant,
  output logic [INIT_ID_W-1:0] owner,
  output logic                 split_pending,
  output logic [INIT_ID_W-1:0] split_owner,
  output logic                 timeout,
  output logic                 split_overflow
);
  arb_state_t state, state_nx;
  logic [NUM_INIT-1:0] grant_nx, resume_prio, prio_nx, park, elig, hit;
  logic [INIT_ID_W-1:0] owner_nx, so_nx, pick;
  logic sp_nx, to_nx, ovf_nx, expire, resumed, found;
  arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state != GRANTED || bus_active),
    .inc    (state == GRANTED && !bus_active),
    .expire (expire)
  );
  // next state: resume is applied to the old slot before any new split fills it
  always_comb begin
    resumed = split_resume && split_pending;
    park = {split_pending && split_owner == 1'b1, split_pending && split_owner == 1'b0};
    elig = req & ~park;
    hit = resume_prio & elig;
    found = |elig;
    pick = hit[0] ? 1'b0 : hit[1] ? 1'b1 : elig[~owner] ? ~owner : owner;
    state_nx = state;
    grant_nx = grant;
    owner_nx = owner;
    sp_nx = resumed ? 1'b0 : split_pending;
    so_nx = split_owner;
    to_nx = 1'b0;
    ovf_nx = 1'b0;
    prio_nx = resume_prio;
    if (state == GRANTED) begin
      if (target_split || txn_done || !req[owner] || expire) begin
        state_nx = RELEASE;
        grant_nx = '0;
      end
      if (target_split && split_pending && !split_resume) ovf_nx = 1'b1;
      else if (target_split) begin
        sp_nx = 1'b1;
        so_nx = owner;
      end
      to_nx = expire && !target_split && !txn_done && req[owner];
    end else begin
      state_nx = found ? GRANTED : IDLE;
      grant_nx = found ? (pick ? 2'b10 : 2'b01) : 2'b00;
      owner_nx = found ? pick : owner;
      prio_nx = resume_prio & req & ~grant_nx;
    end
    if (resumed) prio_nx[split_owner] = 1'b1;
  end
  // register state and every output so the bus sees glitch-free controls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      split_pending <= 1'b0;
      split_owner <= '0;
      timeout <= 1'b0;
      split_overflow <= 1'b0;
      resume_prio <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      owner <= owner_nx;
      split_pending <= sp_nx;
      split_owner <= so_nx;
      timeout <= to_nx;
      split_overflow <= ovf_nx;
      resume_prio <= prio_nx;
    end
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb_serial_bus_arbiter: directed scoreboard bench for the serial bus arbiter
module tb_serial_bus_arbiter;
  logic clk, rst_n, bus_active, txn_done, target_split, split_resume;
  logic [1:0] req, grant;
  logic [0:0] owner, split_owner;
  logic split_pending, timeout, split_overflow;
  typedef struct {
    string tag;
    logic [6:0] v;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  serial_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .bus_active     (bus_active),
    .txn_done       (txn_done),
    .target_split   (target_split),
    .split_resume   (split_resume),
    .grant          (grant),
    .owner          (owner),
    .split_pending  (split_pending),
    .split_owner    (split_owner),
    .timeout        (timeout),
    .split_overflow (split_overflow)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input string t, input logic [1:0] g, input logic ow, sp, so, to, ov);
    q.push_back('{t, {g, ow, sp, so, to, ov}});
  endtask
  task automatic pop_chk();
    exp_t e;
    logic [6:0] obs;
    obs = {grant, owner, split_pending, split_owner, timeout, split_overflow};
    total++;
    if (q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%b", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
      end
    end
  endtask
  task automatic cyc(input string t, input logic [1:0] g, input logic ow, sp, so, to, ov);
    push(t, g, ow, sp, so, to, ov);
    step();
    pop_chk();
  endtask
  initial begin
    logic e;
    rst_n = 1'b0;
    req = 2'b00;
    bus_active = 1'b1;
    txn_done = 1'b0;
    target_split = 1'b0;
    split_resume = 1'b0;
    step();
    cyc("reset", 2'b00, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    req = 2'b01;
    cyc("basic_grant", 2'b01, 0, 0, 0, 0, 0);
    cyc("basic_hold", 2'b01, 0, 0, 0, 0, 0);
    txn_done = 1'b1;
    cyc("basic_release", 2'b00, 0, 0, 0, 0, 0);
    txn_done = 1'b0;
    cyc("basic_regrant", 2'b01, 0, 0, 0, 0, 0);
    req = 2'b00;
    cyc("req_drop", 2'b00, 0, 0, 0, 0, 0);
    cyc("idle", 2'b00, 0, 0, 0, 0, 0);
    req = 2'b11;
    e = 1'b1;
    cyc("rr_first", 2'b10, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      repeat (8) step();
      txn_done = 1'b1;
      cyc("rr_gap", 2'b00, e, 0, 0, 0, 0);
      txn_done = 1'b0;
      e = ~e;
      cyc("rr_next", e ? 2'b10 : 2'b01, e, 0, 0, 0, 0);
    end
    req = 2'b00;
    cyc("rr_drop", 2'b00, 1, 0, 0, 0, 0);
    cyc("rr_idle", 2'b00, 1, 0, 0, 0, 0);
    req = 2'b01;
    cyc("sp_grant0", 2'b01, 0, 0, 0, 0, 0);
    req = 2'b11;
    target_split = 1'b1;
    cyc("sp_park0", 2'b00, 0, 1, 0, 0, 0);
    target_split = 1'b0;
    cyc("sp_grant1", 2'b10, 1, 1, 0, 0, 0);
    split_resume = 1'b1;
    cyc("sp_resume", 2'b10, 1, 0, 0, 0, 0);
    split_resume = 1'b0;
    txn_done = 1'b1;
    cyc("sp_done1", 2'b00, 1, 0, 0, 0, 0);
    txn_done = 1'b0;
    cyc("sp_prio0", 2'b01, 0, 0, 0, 0, 0);
    req = 2'b01;
    target_split = 1'b1;
    cyc("sp_park0b", 2'b00, 0, 1, 0, 0, 0);
    target_split = 1'b0;
    cyc("sp_none_eligible", 2'b00, 0, 1, 0, 0, 0);
    split_resume = 1'b1;
    cyc("sp_resume_idle", 2'b00, 0, 0, 0, 0, 0);
    split_resume = 1'b0;
    req = 2'b11;
    cyc("prio_beats_rr", 2'b01, 0, 0, 0, 0, 0);
    txn_done = 1'b1;
    cyc("prio_done", 2'b00, 0, 0, 0, 0, 0);
    txn_done = 1'b0;
    cyc("prio_cleared", 2'b10, 1, 0, 0, 0, 0);
    txn_done = 1'b1;
    cyc("ov_done1", 2'b00, 1, 0, 0, 0, 0);
    txn_done = 1'b0;
    cyc("ov_grant0", 2'b01, 0, 0, 0, 0, 0);
    target_split = 1'b1;
    cyc("ov_park0", 2'b00, 0, 1, 0, 0, 0);
    target_split = 1'b0;
    cyc("ov_grant1", 2'b10, 1, 1, 0, 0, 0);
    target_split = 1'b1;
    cyc("ov_overflow", 2'b00, 1, 1, 0, 0, 1);
    target_split = 1'b0;
    cyc("ov_regrant1", 2'b10, 1, 1, 0, 0, 0);
    target_split = 1'b1;
    split_resume = 1'b1;
    cyc("split_and_resume", 2'b00, 1, 1, 1, 0, 0);
    target_split = 1'b0;
    split_resume = 1'b0;
    cyc("sr_prio0", 2'b01, 0, 1, 1, 0, 0);
    txn_done = 1'b1;
    cyc("sr_done0", 2'b00, 0, 1, 1, 0, 0);
    txn_done = 1'b0;
    cyc("sr_regrant0", 2'b01, 0, 1, 1, 0, 0);
    split_resume = 1'b1;
    cyc("sr_resume1", 2'b01, 0, 0, 1, 0, 0);
    split_resume = 1'b0;
    txn_done = 1'b1;
    cyc("sr_done0b", 2'b00, 0, 0, 1, 0, 0);
    txn_done = 1'b0;
    cyc("sr_prio1", 2'b10, 1, 0, 1, 0, 0);
    req = 2'b00;
    cyc("sr_drop", 2'b00, 1, 0, 1, 0, 0);
    cyc("sr_idle", 2'b00, 1, 0, 1, 0, 0);
    bus_active = 1'b0;
    req = 2'b01;
    cyc("wd_grant", 2'b01, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc("wd_wait", 2'b01, 0, 0, 1, 0, 0);
    cyc("wd_expire", 2'b00, 0, 0, 1, 1, 0);
    cyc("wd_regrant", 2'b01, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc("wd_wait2", 2'b01, 0, 0, 1, 0, 0);
    bus_active = 1'b1;
    cyc("wd_activity", 2'b01, 0, 0, 1, 0, 0);
    bus_active = 1'b0;
    for (int i = 0; i < 3; i++) cyc("wd_pushed", 2'b01, 0, 0, 1, 0, 0);
    cyc("wd_expire2", 2'b00, 0, 0, 1, 1, 0);
    bus_active = 1'b1;
    cyc("rs_grant0", 2'b01, 0, 0, 1, 0, 0);
    target_split = 1'b1;
    cyc("rs_park0", 2'b00, 0, 1, 0, 0, 0);
    target_split = 1'b0;
    req = 2'b11;
    cyc("rs_grant1", 2'b10, 1, 1, 0, 0, 0);
    rst_n = 1'b0;
    push("rst_async", 2'b00, 0, 0, 0, 0, 0);
    #2;
    pop_chk();
    req = 2'b00;
    cyc("rst_hold", 2'b00, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    req = 2'b01;
    cyc("rst_regrant", 2'b01, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_bus_arbiter.md
# serial_bus_arbiter

Two-initiator arbiter for the serial bus. It takes the `arbiter_req` lines from the initiator ports and drives their `arbiter_grant` inputs one-hot, with round-robin fairness. It owns the bus-level split bookkeeping: it parks a split initiator and regrants it with priority on resume. A watchdog revokes grants when the owning initiator stops driving the bus.

## Interface
- `TIMEOUT_CYCLES`, 64: consecutive idle granted cycles before forced release; must be ≥2.
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  2  per-initiator bus request, level
- `bus_active`  in  1  owner is shifting, i.e. the OR of the initiator ports' `bus_data_out_valid`
- `txn_done`  in  1  one-cycle pulse: the target acked, transaction complete
- `target_split`  in  1  one-cycle pulse: the target splits the current transaction
- `split_resume`  in  1  one-cycle pulse: the split target is ready to complete
- `grant`  out  2  one-hot grant, or 0
- `owner`  out  1  index of the current or last granted initiator
- `split_pending`  out  1  split slot occupied
- `split_owner`  out  1  initiator parked in the split slot
- `timeout`  out  1  one-cycle pulse when the watchdog revokes a grant
- `split_overflow`  out  1  one-cycle pulse when a split is dropped because the slot is full

## Operation
- States: `IDLE`, `GRANTED`, `RELEASE`.
- **Eligible requester:**
  - `req[i]`=1.
  - Not parked: `split_pending`=0 or `split_owner`≠i.
- **Arbitration** runs in `IDLE` and `RELEASE`, in this order:
  - `resume_prio[i]` set and `req[i]`=1: grant i.
  - Else round-robin: prefer `~owner`, else `owner`.
  - No eligible requester: go to `IDLE` with `grant`=0.
- If `resume_prio[i]` is set but `req[i]`=0 during arbitration, clear `resume_prio[i]`.
- **Release events in `GRANTED`**, highest priority first:
  - `target_split`
  - `txn_done`
  - `req[owner]`=0
  - watchdog expiry
- Every release event drives `grant`=0 and moves to `RELEASE`.
- **Split, slot empty:** `split_pending`←1, `split_owner`←`owner`.
- **Split, slot full:** treated as `txn_done`, and `split_overflow` pulses.
- **`split_resume` with slot full:** clear the slot, set `resume_prio[split_owner]`. This is honoured in any state, including the same cycle as a new split; in that case the resume applies to the old slot contents first and the new split then fills the slot.
- **`split_resume` with slot empty:** ignored.
- `resume_prio[i]` clears when i is granted.
- **Watchdog:**
  - Counter is cleared on entry to `GRANTED` and on every cycle with `bus_active`=1.
  - It increments on every `GRANTED` cycle with `bus_active`=0.
  - Expiry: `bus_active`=0 with counter = `TIMEOUT_CYCLES`−1. `timeout` pulses with the release.
  - Counter width is `$clog2(TIMEOUT_CYCLES)`. It saturates and never wraps.
- **Inputs outside `GRANTED`:** `txn_done`, `target_split` and `bus_active` are ignored.

## Timing
- All outputs are registered.
- **Reset values:**
  - `grant`=0, `owner`=0, `split_pending`=0, `split_owner`=0, `timeout`=0, `split_overflow`=0.
  - State `IDLE`, `resume_prio`=0, watchdog counter 0.
- **Grant latency:** `req` sampled high at edge k in `IDLE` gives `grant` high after edge k.
- **Release:** event sampled at edge k gives `grant`=0 after k; `RELEASE` lasts one cycle; the earliest new grant is after edge k+1. This is the one-cycle bus turnaround.
- `split_pending` and `split_owner` update at the same edge as the grant drop.
- `timeout` and `split_overflow` are high for exactly one cycle, coincident with the first `grant`=0 cycle.
- **Reset asserted mid-transaction:** all outputs and state return to reset values immediately. Parked and priority information is lost.

## Structure
- `serial_bus_pkg`:
  - `arb_state_t` enum (`IDLE`/`GRANTED`/`RELEASE`)
  - `NUM_INIT`=2
  - `INIT_ID_W`=1
- Sub-module `arb_watchdog`:
  - Parameter `TIMEOUT_CYCLES`.
  - Inputs `clr`, `inc`.
  - Output `expire`, asserted when `inc` is high and count = `TIMEOUT_CYCLES`−1.
- FSM, split slot and `resume_prio` stay in `serial_bus_arbiter`.

## Test plan
- **Basic grant:** `req`=01 from reset → `grant`=01 one cycle later; `txn_done` pulse → `grant`=00 for exactly one cycle, then 01 again if `req[0]` is still high.
- **Round-robin:** `req`=11 held, `txn_done` every 10 cycles → grant sequence 01, 10, 01, 10, with one gap cycle between each.
- **Split:**
  - Owner 0 gets `target_split` → `split_pending`=1, `split_owner`=0, then `grant`=10 with `req`=11.
  - `split_resume` during initiator 1's grant, then `txn_done` → `grant`=01 even though round-robin favours 1.
- **Overflow:** split parks 0; 1 is granted and gets `target_split` → `split_overflow` pulses, `split_owner` stays 0, `grant` goes to 00 and then 10 again.
- **Watchdog:** `TIMEOUT_CYCLES`=4, grant 0, `bus_active`=0 → `timeout` and the grant drop on the 5th cycle after the grant; an activity pulse at cycle 3 pushes expiry 4 cycles later.
- **Reset mid-split:** `split_pending`=1 and `grant`=10, assert `rst_n`=0 asynchronously → all outputs 0 within the same cycle; after release, `req`=01 gives a normal grant.
